// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that sequences two requesters'
// commands (increment / load / clear) onto an external 3-bit counter.
// Each accepted command drives one registered strobe. One cycle later the
// winner gets a done pulse, and the counter value then reflects the command.
// An increment at cnt==7 is refused: no strobe is driven, and done and err
// pulse together on the next cycle.
module counter_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   input  logic [2:0] val0,
   input  logic [2:0] val1,
   input  logic [2:0] cnt,
   output logic       cnt_rst,
   output logic       cnt_ld,
   output logic       cnt_inc,
   output logic [2:0] cnt_data,
   output logic       done0,
   output logic       done1,
   output logic       err0,
   output logic       err1
);

   // state | meaning
   // INIT  | post-reset cycle: counter clear strobe high, requests ignored
   // IDLE  | arbitrate; accept at most one command per visit
   // ISSUE | the accepted command's strobe is high (none for no-op)
   // WAIT  | counter shows the result; winner's done (and err) pulse
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   localparam logic [1:0] OP_INC = 2'b01;
   localparam logic [1:0] OP_LD  = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       win_q, win_d;
   logic       cnt_rst_q, cnt_rst_d;
   logic       cnt_ld_q, cnt_ld_d;
   logic       cnt_inc_q, cnt_inc_d;
   logic [2:0] cnt_data_q, cnt_data_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic       err0_q, err0_d;
   logic       err1_q, err1_d;

   logic       any_req;
   logic       win;
   logic [1:0] sel_op;
   logic [2:0] sel_val;

   // Round-robin pick: a lone requester wins; a tie goes to the one not at ptr
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         win = ~ptr_q;
      end else begin
         win = req1;
      end
      sel_op  = win ? op1 : op0;
      sel_val = win ? val1 : val0;
   end

   // Next state and next registered outputs
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      cnt_rst_d  = 1'b0;
      cnt_ld_d   = 1'b0;
      cnt_inc_d  = 1'b0;
      cnt_data_d = cnt_data_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      err0_d     = 1'b0;
      err1_d     = 1'b0;
      case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (any_req) begin
               ptr_d = win;
               win_d = win;
               if (sel_op == OP_INC && cnt == 3'd7) begin
                  // Refused increment: skip ISSUE so the counter never wraps
                  state_d = ST_WAIT;
                  done0_d = ~win;
                  done1_d = win;
                  err0_d  = ~win;
                  err1_d  = win;
               end else begin
                  state_d = ST_ISSUE;
                  case (sel_op)
                     OP_INC: cnt_inc_d = 1'b1;
                     OP_LD: begin
                        cnt_ld_d   = 1'b1;
                        cnt_data_d = sel_val;
                     end
                     OP_CLR:  cnt_rst_d = 1'b1;
                     default: ;
                  endcase
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            done0_d = ~win_q;
            done1_d = win_q;
         end
         ST_WAIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and output registers; reset parks in INIT with the clear strobe up
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         ptr_q      <= 1'b1;
         win_q      <= 1'b0;
         cnt_rst_q  <= 1'b1;
         cnt_ld_q   <= 1'b0;
         cnt_inc_q  <= 1'b0;
         cnt_data_q <= 3'd0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         cnt_rst_q  <= cnt_rst_d;
         cnt_ld_q   <= cnt_ld_d;
         cnt_inc_q  <= cnt_inc_d;
         cnt_data_q <= cnt_data_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         err0_q     <= err0_d;
         err1_q     <= err1_d;
      end
   end

   assign cnt_rst  = cnt_rst_q;
   assign cnt_ld   = cnt_ld_q;
   assign cnt_inc  = cnt_inc_q;
   assign cnt_data = cnt_data_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign err0     = err0_q;
   assign err1     = err1_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Testbench for counter_arbiter. It contains the controlled 3-bit counter,
// a transaction-level expectation model, a per-cycle compare process and
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_counter_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] op0 = 2'b00, op1 = 2'b00;
   logic [2:0] val0 = 3'd0, val1 = 3'd0;
   logic [2:0] cnt = 3'd5;
   logic       cnt_rst, cnt_ld, cnt_inc;
   logic [2:0] cnt_data;
   logic       done0, done1, err0, err1;

   int tests = 0;
   int fails = 0;

   counter_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .op0(op0), .op1(op1),
      .val0(val0), .val1(val1),
      .cnt(cnt),
      .cnt_rst(cnt_rst), .cnt_ld(cnt_ld), .cnt_inc(cnt_inc), .cnt_data(cnt_data),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1)
   );

   always #5 clk = ~clk;

   // The counter being controlled
   always @(posedge clk) begin
      if (cnt_rst)      cnt <= 3'd0;
      else if (cnt_ld)  cnt <= cnt_data;
      else if (cnt_inc) cnt <= cnt + 3'd1;
   end

   // Expectation model. It schedules outputs per accepted transaction and
   // blocks further acceptance until free_at.
   // Bit layout: {cnt_rst, cnt_ld, cnt_inc, done0, done1, err0, err1}
   logic [6:0] exp_cur, exp_nxt;
   logic [2:0] exp_data;
   int         t, free_at;
   logic       last_win;
   bit         model_ok = 1'b0;
   logic       m_w;
   logic [1:0] m_o;
   logic [2:0] m_v;

   always begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         exp_cur  = 7'b1000000;
         exp_nxt  = 7'b0;
         exp_data = 3'd0;
         t        = 0;
         free_at  = 1;
         last_win = 1'b1;
         model_ok = 1'b1;
      end else if (model_ok) begin
         exp_cur = exp_nxt;
         exp_nxt = 7'b0;
         if (t >= free_at && (req0 || req1)) begin
            if (req0 && req1) m_w = ~last_win;
            else              m_w = req1;
            last_win = m_w;
            m_o = m_w ? op1 : op0;
            m_v = m_w ? val1 : val0;
            if (m_o == 2'b01 && cnt == 3'd7) begin
               exp_cur = m_w ? 7'b0000101 : 7'b0001010;
               free_at = t + 2;
            end else begin
               case (m_o)
                  2'b01: exp_cur = 7'b0010000;
                  2'b10: begin
                     exp_cur  = 7'b0100000;
                     exp_data = m_v;
                  end
                  2'b11:   exp_cur = 7'b1000000;
                  default: exp_cur = 7'b0000000;
               endcase
               exp_nxt = m_w ? 7'b0000100 : 7'b0001000;
               free_at = t + 3;
            end
         end
         t++;
      end
   end

   // Per-cycle compare against the model plus counter-safety invariants
   logic [6:0] act;
   always begin
      @(negedge clk);
      if (model_ok) begin
         act = {cnt_rst, cnt_ld, cnt_inc, done0, done1, err0, err1};
         tests++;
         if (act !== exp_cur || cnt_data !== exp_data) begin
            fails++;
            $display("FAIL cycle_check @%0t: got outputs=%b data=%0d, expected outputs=%b data=%0d",
                     $time, act, cnt_data, exp_cur, exp_data);
         end
         tests++;
         if ($countones({cnt_rst, cnt_ld, cnt_inc}) > 1 || (cnt_inc && cnt == 3'd7)) begin
            fails++;
            $display("FAIL strobe_safety @%0t: got strobes=%b cnt=%0d, expected at most one strobe and no inc at 7",
                     $time, {cnt_rst, cnt_ld, cnt_inc}, cnt);
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Issue one command from an IDLE cycle. Return the cycles until done and
   // the err flag seen with done, then finish back in an IDLE cycle.
   task automatic cmd(input bit who, input logic [1:0] op, input logic [2:0] val,
                      input string name, output int lat, output int err);
      if (who) begin req1 = 1'b1; op1 = op; val1 = val; end
      else     begin req0 = 1'b1; op0 = op; val0 = val; end
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(who ? done1 : done0) && lat < 20);
      err = int'(who ? err1 : err0);
      if (!(who ? done1 : done0)) begin
         tests++;
         fails++;
         $display("FAIL %s: got no done%0d, expected one within 20 cycles", name, who);
      end
      if (who) req1 = 1'b0; else req0 = 1'b0;
      tick();
   endtask

   int lat, err, n, hits;
   int win_seq[4], cyc_seq[4], cnt_seq[4];

   initial begin
      // Reset release with req0 inc pending: ignored in INIT, accepted in IDLE
      req0 = 1'b1; op0 = 2'b01;
      tick(3);
      check("reset_cnt_rst", int'(cnt_rst), 1);
      check("reset_done0", int'(done0), 0);
      check("reset_cnt_data", int'(cnt_data), 0);
      rst = 1'b1;
      #1 check("init_cnt_rst", int'(cnt_rst), 1);
      tick();
      check("idle_no_strobe", int'({cnt_rst, cnt_ld, cnt_inc}), 0);
      tick();
      check("issue_inc", int'(cnt_inc), 1);
      tick();
      check("done0_two_after", int'(done0), 1);
      check("cnt_after_inc", int'(cnt), 1);
      req0 = 1'b0;
      tick();

      // req1 load 5; inputs change after acceptance and must not matter
      req1 = 1'b1; op1 = 2'b10; val1 = 3'd5;
      tick();
      check("ld_strobe", int'(cnt_ld), 1);
      check("ld_data", int'(cnt_data), 5);
      val1 = 3'd2; op1 = 2'b11;
      tick();
      check("done1_ld", int'(done1), 1);
      check("cnt_after_ld", int'(cnt), 5);
      check("data_held", int'(cnt_data), 5);
      req1 = 1'b0; op1 = 2'b00;
      tick();

      // Step to 6, then clear
      cmd(1'b0, 2'b01, 3'd0, "inc_to_6", lat, err);
      check("inc_latency", lat, 2);
      check("cnt_before_clr", int'(cnt), 6);
      req0 = 1'b1; op0 = 2'b11;
      tick();
      check("clr_strobe", int'(cnt_rst), 1);
      tick();
      check("done0_clr", int'(done0), 1);
      check("cnt_after_clr", int'(cnt), 0);
      req0 = 1'b0;
      tick();

      // No-op from req1: done with no strobe, leaves ptr at requester 1
      cmd(1'b1, 2'b00, 3'd0, "noop", lat, err);
      check("noop_latency", lat, 2);
      check("noop_cnt", int'(cnt), 0);

      // Both increment continuously: grants 0,1,0,1 spaced 3 cycles
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b01; op1 = 2'b01;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         if (done0 || done1) begin
            win_seq[n] = int'(done1);
            cyc_seq[n] = c;
            cnt_seq[n] = int'(cnt);
            n++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("rr_done_count", n, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_winner_%0d", i), win_seq[i], i % 2);
         check($sformatf("rr_cnt_%0d", i), cnt_seq[i], i + 1);
         check($sformatf("rr_cycle_%0d", i), cyc_seq[i], 1 + 3 * i);
      end

      // Saturation: load 7, then refused increments
      cmd(1'b0, 2'b10, 3'd7, "ld7", lat, err);
      check("cnt_after_ld7", int'(cnt), 7);
      cmd(1'b0, 2'b01, 3'd0, "inc_at_7_r0", lat, err);
      check("refused_latency_r0", lat, 1);
      check("refused_err0", err, 1);
      check("cnt_stays_7", int'(cnt), 7);
      cmd(1'b1, 2'b01, 3'd0, "inc_at_7_r1", lat, err);
      check("refused_latency_r1", lat, 1);
      check("refused_err1", err, 1);
      // A refused grant still moves ptr: tie now goes to 0, then to 1
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b01; op1 = 2'b01;
      tick();
      check("tie_after_refuse_0", int'({done0, err0, done1, err1}), 4'b1100);
      tick(2);
      check("tie_after_refuse_1", int'({done0, err0, done1, err1}), 4'b0011);
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // Reset asserted during ISSUE aborts the command
      cmd(1'b1, 2'b10, 3'd3, "ld3", lat, err);
      req0 = 1'b1; op0 = 2'b01;
      tick();
      check("abort_issue_inc", int'(cnt_inc), 1);
      #1 rst = 1'b0;
      #1 check("abort_strobes", int'({cnt_rst, cnt_ld, cnt_inc}), 3'b100);
      req0 = 1'b0;
      tick(2);
      rst = 1'b1;
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done0 || done1 || err0 || err1) hits++;
      end
      check("abort_no_done", hits, 0);
      check("abort_cnt_cleared", int'(cnt), 0);

      // After reset, ptr favours requester 0 on the first tie
      req0 = 1'b1; req1 = 1'b1; op0 = 2'b01; op1 = 2'b00;
      tick(2);
      check("reset_tie_winner", int'({done0, done1}), 2'b10);
      req0 = 1'b0; req1 = 1'b0;
      tick(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100us");
      $fatal(1);
   end

endmodule
